multiplier_radix_taint_track: RTL and testbench
===============================================

MULTIPLIER_RADIX_TAINT_TRACK -- requirements
Module: multiplier_radix_taint_track

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; SHALL be a multiple of RADIX_BITS.
REQ-002 Parameter RADIX_BITS, default 2: multiplier bits consumed per iteration (1, 2 or 4).
REQ-003 Parameter SIGNED, default 0: 0 = unsigned operands; 1 = two's-complement operands.
REQ-004 Clock and reset SHALL be: one clock `clk`; reset `rst`, asynchronous, active-high.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  async active-high reset
- start, start_t  in  1,1  request; taint of request
- multiplier, multiplier_t  in  WIDTH,1  operand A; word taint
- multiplicand, multiplicand_t  in  WIDTH,1  operand B; word taint
- ready, ready_t  out  1,1  idle, start accepted; taint
- product, product_t  out  2*WIDTH,1  result; word taint
- productDone, productDone_t  out  1,1  one-cycle result-valid pulse; taint
- kill  in  1  taint clear (only with TAINT_KILL_EN)

Function
REQ-006 FSM states SHALL be IDLE, LOAD, RUN, DONE.
REQ-007 IDLE->LOAD SHALL occur on start=1; start in any other state SHALL be ignored.
REQ-008 LOAD SHALL latch both operands, clear the running sum and reset the iteration counter to 0.
REQ-009 RUN SHALL last exactly ITERS = WIDTH/RADIX_BITS cycles, then go to DONE.
REQ-010 DONE SHALL assert productDone for one cycle, then return to IDLE.
REQ-011 Latency from the start cycle to productDone SHALL be ITERS+2 cycles, independent of operand values.
REQ-012 Each RUN cycle SHALL add multiplicand times the low RADIX_BITS of the multiplier register to the running sum, then shift both by RADIX_BITS.
REQ-013 With SIGNED=1, the last iteration SHALL weight the top digit negatively so the product is exact two's-complement.
REQ-014 product SHALL hold the exact 2*WIDTH-bit result from DONE until the next LOAD; no overflow is possible.
REQ-015 ready SHALL equal 1 only in IDLE.
REQ-016 Operand changes after LOAD SHALL NOT affect the product in progress.
REQ-017 Control taint: a state-taint flag SHALL be set when start is accepted with start_t=1 and cleared on return to IDLE.
REQ-018 ready_t and productDone_t SHALL equal the state-taint flag.
REQ-019 Data taint: at LOAD, product_t SHALL become multiplier_t | multiplicand_t | state taint, held until the next LOAD.
REQ-020 Operand values SHALL never influence control taint.

Reset
REQ-021 While rst=1, the block SHALL be in IDLE with ready=1, productDone=0, product=0, counter=0 and all taint outputs 0.
REQ-022 Reset asserted mid-RUN SHALL abandon the operation with no productDone pulse.

Configuration
REQ-023 The configuration macro SHALL be TAINT_KILL_EN.
REQ-024 With TAINT_KILL_EN defined, the kill port SHALL exist; kill=1 SHALL clear all taint registers at the next edge and SHALL NOT change data or FSM state.
REQ-025 Without TAINT_KILL_EN, there SHALL be no kill port; taint clears only via reset and REQ-017/REQ-019.

Structure
REQ-026 Package mult_taint_pkg SHALL hold the FSM state encoding and the ITERS/counter-width helper constants.
REQ-027 Sub-module multiplier_radix_datapath SHALL hold the operand, sum and product registers and their taint bits, driven by control strobes from the FSM.

Verification
REQ-028 The bench SHALL cover these scenarios:
- WIDTH=8, RADIX_BITS=2, SIGNED=0: 200*100 -> product=20000, productDone exactly 6 cycles after start.
- SIGNED=1, WIDTH=8: -3 * 5 -> product=16'hFFF1; 127 * -128 -> 16'hC080; latency identical to REQ-011.
- multiplier_t=1, start_t=0 -> product_t=1 at DONE; ready_t=0 and productDone_t=0 throughout.
- start_t=1 -> ready_t/productDone_t=1 until IDLE; second start during RUN is ignored with no extra pulse.
- rst pulse at RUN cycle 2 -> immediate IDLE, product=0, no productDone; the next start runs normally.
- TAINT_KILL_EN defined: kill during RUN -> all taint 0 on the next edge, product value unaffected.

Source files
------------

// File: rtl/mult_taint_pkg.sv
// -----------------------------------------------------------------------------
// mult_taint_pkg
// Shared definitions for the radix-2^k sequential multiplier with taint
// tracking. Holds the FSM state encoding and the helper functions that derive
// the iteration count and the iteration-counter width from the operand width
// and the radix.
// No ports (package).
// -----------------------------------------------------------------------------
package mult_taint_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH      = 32;
    localparam int DEFAULT_RADIX_BITS = 2;

    // Number of RUN cycles: one multiplier digit is consumed per cycle.
    function automatic int iters_of(input int width, input int radix_bits);
        return width / radix_bits;
    endfunction

    // Counter only has to reach iters-1; keep at least one bit.
    function automatic int cnt_w_of(input int iters);
        return (iters > 1) ? $clog2(iters) : 1;
    endfunction

    localparam int DEFAULT_ITERS = iters_of(DEFAULT_WIDTH, DEFAULT_RADIX_BITS);
    localparam int DEFAULT_CNT_W = cnt_w_of(DEFAULT_ITERS);

endpackage

// File: rtl/multiplier_radix_datapath.sv
// -----------------------------------------------------------------------------
// multiplier_radix_datapath
// Operand, running-sum and product registers of the radix-2^RADIX_BITS
// shift-and-add multiplier, plus the product data-taint bit.
// Ports:
//   clk, rst          clock, async active-high reset (product/product_t only)
//   load              latch operands, clear running sum, capture data taint
//   step              perform one iteration (add digit*multiplicand, shift)
//   last              current step is the final one (signed top digit, write product)
//   taint_clr         clear the product taint bit
//   state_taint       control taint folded into the data taint at load
//   multiplier(_t)    operand A and its word taint
//   multiplicand(_t)  operand B and its word taint
//   product(_t)       2*WIDTH-bit result and its word taint
// -----------------------------------------------------------------------------
module multiplier_radix_datapath
    import mult_taint_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int RADIX_BITS = DEFAULT_RADIX_BITS,
    parameter int SIGNED     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 last,
    input  logic                 taint_clr,
    input  logic                 state_taint,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 multiplier_t,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic                 multiplicand_t,
    output logic [2*WIDTH-1:0]   product,
    output logic                 product_t
);

    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0]        mplier_q;
    logic signed [PW-1:0]    mcand_q;
    logic signed [PW-1:0]    sum_q;
    logic signed [PW-1:0]    mcand_ext;
    logic signed [RADIX_BITS:0] digit;
    logic signed [PW-1:0]    digit_ext;
    logic signed [PW-1:0]    partial;
    logic signed [PW-1:0]    sum_next;

    always_comb begin
        // Multiplicand is widened once at load so every partial product is
        // already aligned at full product width.
        if (SIGNED != 0) begin
            mcand_ext = {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
        end else begin
            mcand_ext = {{WIDTH{1'b0}}, multiplicand};
        end

        // Digits are unsigned except the top one of a signed multiplier,
        // whose MSB carries negative weight.
        if ((SIGNED != 0) && last) begin
            digit = {mplier_q[RADIX_BITS-1], mplier_q[RADIX_BITS-1:0]};
        end else begin
            digit = {1'b0, mplier_q[RADIX_BITS-1:0]};
        end
        digit_ext = {{(PW-RADIX_BITS-1){digit[RADIX_BITS]}}, digit};

        partial  = mcand_q * digit_ext;
        sum_next = sum_q + partial;
    end

    // Working registers: fully rewritten at load, so no reset needed.
    always_ff @(posedge clk) begin
        if (load) begin
            mplier_q <= multiplier;
            mcand_q  <= mcand_ext;
            sum_q    <= '0;
        end else if (step) begin
            mplier_q <= mplier_q >> RADIX_BITS;
            mcand_q  <= mcand_q <<< RADIX_BITS;
            sum_q    <= sum_next;
        end
    end

    // Visible product only changes when the final sum is known.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
        end else if (step && last) begin
            product <= sum_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product_t <= 1'b0;
        end else if (taint_clr) begin
            product_t <= 1'b0;
        end else if (load) begin
            product_t <= multiplier_t | multiplicand_t | state_taint;
        end
    end

endmodule

// File: rtl/multiplier_radix_taint_track.sv
// -----------------------------------------------------------------------------
// multiplier_radix_taint_track
// Sequential radix-2^RADIX_BITS multiplier (IDLE -> LOAD -> RUN x ITERS -> DONE)
// with control-taint and data-taint tracking. Latency from the accepted start
// cycle to the productDone pulse is ITERS+2 cycles.
// Optional feature macro: TAINT_KILL_EN adds the kill port, which clears all
// taint registers at the next edge without touching data or FSM state.
// Ports:
//   clk, rst                 clock, async active-high reset
//   kill                     taint clear (TAINT_KILL_EN builds only)
//   start, start_t           request and its taint
//   multiplier(_t)           operand A and word taint
//   multiplicand(_t)         operand B and word taint
//   ready, ready_t           high only in IDLE; control taint
//   product, product_t       2*WIDTH-bit result and word taint
//   productDone(_t)          one-cycle result-valid pulse; control taint
// -----------------------------------------------------------------------------
module multiplier_radix_taint_track
    import mult_taint_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int RADIX_BITS = DEFAULT_RADIX_BITS,
    parameter int SIGNED     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef TAINT_KILL_EN
    input  logic                 kill,
`endif
    input  logic                 start,
    input  logic                 start_t,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 multiplier_t,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic                 multiplicand_t,
    output logic                 ready,
    output logic                 ready_t,
    output logic [2*WIDTH-1:0]   product,
    output logic                 product_t,
    output logic                 productDone,
    output logic                 productDone_t
);

    localparam int ITERS = iters_of(WIDTH, RADIX_BITS);
    localparam int CNT_W = cnt_w_of(ITERS);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic             state_taint;
    logic             load;
    logic             step;
    logic             last;
    logic             taint_clr;

`ifdef TAINT_KILL_EN
    assign taint_clr = kill;
`else
    assign taint_clr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        load        = 1'b0;
        step        = 1'b0;
        last        = 1'b0;
        ready       = 1'b0;
        productDone = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                load    = 1'b1;
                state_n = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(ITERS - 1)) begin
                    last    = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                productDone = 1'b1;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    // Control taint depends only on start_t and the FSM, never on operand data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_taint <= 1'b0;
        end else if (taint_clr) begin
            state_taint <= 1'b0;
        end else if ((state == IDLE) && start) begin
            state_taint <= start_t;
        end else if (state == DONE) begin
            state_taint <= 1'b0;
        end
    end

    assign ready_t       = state_taint;
    assign productDone_t = state_taint;

    multiplier_radix_datapath #(
        .WIDTH      (WIDTH),
        .RADIX_BITS (RADIX_BITS),
        .SIGNED     (SIGNED)
    ) u_datapath (
        .clk            (clk),
        .rst            (rst),
        .load           (load),
        .step           (step),
        .last           (last),
        .taint_clr      (taint_clr),
        .state_taint    (state_taint),
        .multiplier     (multiplier),
        .multiplier_t   (multiplier_t),
        .multiplicand   (multiplicand),
        .multiplicand_t (multiplicand_t),
        .product        (product),
        .product_t      (product_t)
    );

endmodule

// File: tb/tb_multiplier_radix_taint_track.sv
// -----------------------------------------------------------------------------
// tb_multiplier_radix_taint_track
// Scoreboard bench: an unsigned and a signed 8-bit, radix-4 instance share all
// stimulus. The driver pushes expected results (computed with plain integer
// multiplication) into a queue; a monitor on the falling edge pops them when
// productDone appears and checks control/taint outputs every cycle.
// -----------------------------------------------------------------------------
module tb_multiplier_radix_taint_track;

    localparam int W     = 8;
    localparam int R     = 2;
    localparam int ITERS = W / R;
    localparam int NEVER = 1 << 30;

    logic clk;
    logic rst;
    logic start, start_t;
    logic [W-1:0] multiplier, multiplicand;
    logic multiplier_t, multiplicand_t;
`ifdef TAINT_KILL_EN
    logic kill;
`endif

    logic ready_u, ready_t_u, pd_u, pd_t_u, product_t_u;
    logic ready_s, ready_t_s, pd_s, pd_t_s, product_t_s;
    logic [2*W-1:0] product_u, product_s;

    multiplier_radix_taint_track #(.WIDTH(W), .RADIX_BITS(R), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst),
`ifdef TAINT_KILL_EN
        .kill(kill),
`endif
        .start(start), .start_t(start_t),
        .multiplier(multiplier), .multiplier_t(multiplier_t),
        .multiplicand(multiplicand), .multiplicand_t(multiplicand_t),
        .ready(ready_u), .ready_t(ready_t_u),
        .product(product_u), .product_t(product_t_u),
        .productDone(pd_u), .productDone_t(pd_t_u)
    );

    multiplier_radix_taint_track #(.WIDTH(W), .RADIX_BITS(R), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst),
`ifdef TAINT_KILL_EN
        .kill(kill),
`endif
        .start(start), .start_t(start_t),
        .multiplier(multiplier), .multiplier_t(multiplier_t),
        .multiplicand(multiplicand), .multiplicand_t(multiplicand_t),
        .ready(ready_s), .ready_t(ready_t_s),
        .product(product_s), .product_t(product_t_s),
        .productDone(pd_s), .productDone_t(pd_t_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] pu;
        logic [2*W-1:0] ps;
        logic           pt;
        int             done_cyc;
    } item_t;

    item_t sb_q[$];

    // Reference-model state owned by the driver.
    bit act = 1'b0;
    int lo = 0, hi = -1;
    bit ct = 1'b0;
    int kill_after = NEVER;
    bit stim_done = 1'b0;

    // Monitor-owned state.
    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] last_u = '0, last_s = '0;
    logic last_pt = 1'b0;
    bit in_busy, exp_ct, exp_pulse, exp_pt;
    item_t it;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (stim_done) begin
            chk("scoreboard_empty", sb_q.size(), 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end else if (rst) begin
            sb_q.delete();
            last_u  = '0;
            last_s  = '0;
            last_pt = 1'b0;
            chk("rst_ready", {ready_u, ready_s}, 2'b11);
            chk("rst_done", {pd_u, pd_s}, 2'b00);
            chk("rst_product_u", product_u, 0);
            chk("rst_product_s", product_s, 0);
            chk("rst_taints", {ready_t_u, ready_t_s, pd_t_u, pd_t_s, product_t_u, product_t_s}, 0);
        end else begin
            in_busy   = act && (cyc >= lo) && (cyc <= hi);
            exp_ct    = in_busy && ct && (cyc <= kill_after);
            exp_pulse = act && (cyc == hi);
            chk("ready", {ready_u, ready_s}, {2{!in_busy}});
            chk("ready_t", {ready_t_u, ready_t_s}, {2{exp_ct}});
            chk("productDone_t", {pd_t_u, pd_t_s}, {2{exp_ct}});
            chk("productDone", {pd_u, pd_s}, {2{exp_pulse}});
            if (pd_u || pd_s) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    it = sb_q.pop_front();
                    exp_pt = it.pt && (cyc <= kill_after);
                    chk("product_u", product_u, it.pu);
                    chk("product_s", product_s, it.ps);
                    chk("product_t", {product_t_u, product_t_s}, {2{exp_pt}});
                    chk("latency", cyc, it.done_cyc);
                    last_u  = it.pu;
                    last_s  = it.ps;
                    last_pt = exp_pt;
                end
            end else if (!in_busy) begin
                chk("hold_product_u", product_u, last_u);
                chk("hold_product_s", product_s, last_s);
                chk("hold_product_t", {product_t_u, product_t_s}, {2{last_pt}});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // One transaction. abort_off/kill_off/spur_off are cycle offsets from the
    // start cycle (0 = not used). spur_off must stay within RUN.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit mt, input bit bt, input bit st,
                           input int abort_off, input int kill_off, input int spur_off);
        item_t nx;
        logic signed [2*W-1:0] sa, sb;
        int s;
        while (act && cyc <= hi) tick();
        start          = 1'b1;
        start_t        = st;
        multiplier     = a;
        multiplicand   = b;
        multiplier_t   = mt;
        multiplicand_t = bt;
        s  = cyc;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        nx.pu       = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        nx.ps       = sa * sb;
        nx.pt       = mt | bt | st;
        nx.done_cyc = s + ITERS + 2;
        sb_q.push_back(nx);
        act = 1'b1;
        lo  = s + 1;
        hi  = s + ITERS + 2;
        ct  = st;
        kill_after = NEVER;
        for (int off = 1; off <= ITERS + 2; off++) begin
            tick();
            start = 1'b0;
`ifdef TAINT_KILL_EN
            kill = 1'b0;
`endif
            if (off == 2) begin
                // Operands are already captured; scribble over them.
                multiplier     = W'($urandom);
                multiplicand   = W'($urandom);
                multiplier_t   = 1'($urandom);
                multiplicand_t = 1'($urandom);
                start_t        = 1'($urandom);
            end
            if (off == spur_off) begin
                start   = 1'b1;
                start_t = 1'b1;
            end
            if (off == abort_off) begin
                start = 1'b0;
                rst   = 1'b1;
                act   = 1'b0;
                tick();
                rst = 1'b0;
                return;
            end
`ifdef TAINT_KILL_EN
            if (off == kill_off) begin
                kill       = 1'b1;
                kill_after = cyc;
            end
`endif
        end
`ifndef TAINT_KILL_EN
        if (kill_off < 0) $display("kill offset ignored");
`endif
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        start_t        = 1'b0;
        multiplier     = '0;
        multiplicand   = '0;
        multiplier_t   = 1'b0;
        multiplicand_t = 1'b0;
`ifdef TAINT_KILL_EN
        kill = 1'b0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        tick();

        run_txn(8'd200, 8'd100, 0, 0, 0, 0, 0, 0);   // 20000
        run_txn(8'hFD,  8'd5,   0, 0, 0, 0, 0, 0);   // signed -15
        run_txn(8'd127, 8'h80,  0, 0, 0, 0, 0, 0);   // signed -16256
        run_txn(8'hFF,  8'hFF,  0, 0, 0, 0, 0, 0);
        run_txn(8'h00,  8'hA5,  0, 0, 0, 0, 0, 0);
        run_txn(8'h80,  8'h80,  0, 0, 0, 0, 0, 0);
        run_txn(8'd37,  8'd91,  1, 0, 0, 0, 0, 0);   // data taint only
        run_txn(8'd12,  8'd34,  0, 0, 1, 0, 0, 3);   // control taint + ignored start
        run_txn(8'd77,  8'd55,  0, 1, 0, 3, 0, 0);   // reset at RUN cycle 2
        run_txn(8'd200, 8'd100, 0, 0, 0, 0, 0, 0);   // normal after abort
`ifdef TAINT_KILL_EN
        run_txn(8'd99,  8'd201, 1, 1, 1, 0, 3, 0);   // kill during RUN
`endif

        for (int n = 0; n < 40; n++) begin
            int ab, kl, sp;
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, ITERS + 1)) : 0;
            kl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, ITERS + 1)) : 0;
            sp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, ITERS + 1)) : 0;
            run_txn(W'($urandom), W'($urandom), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 3) == 0), 1'($urandom), ab, kl, sp);
            repeat ($urandom_range(0, 2)) tick();
        end

        while (act && cyc <= hi) tick();
        repeat (3) tick();
        stim_done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
